pipe_stage_buf: RTL
===================

Name: pipe_stage_buf

Overview:
Parametrised pipeline stage register for the core, generalising the fixed inter-stage latches (e.g. EX->MEM) into one reusable slice.
- Carries an opaque DATA_W-bit payload bundle (control + data fields concatenated by the instantiator) under a valid/ready handshake.
- Supports synchronous flush and a saturating backpressure counter.
- Optional 2-entry skid mode gives full throughput with a registered upstream ready, breaking the ready timing path between stages.

Parameters:
DATA_W, 32, payload width in bits (>=1)
SKID, 1, 1 = 2-entry skid buffer with registered o_rdy; 0 = single register with combinational o_rdy
CLR_ON_FLUSH, 1, 1 = payload registers zeroed on flush; 0 = payload left unchanged, only valids cleared
CNT_W, 16, width of stall counter

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_flush  in  1  synchronous kill of all held entries and of any same-cycle input beat
i_vld  in  1  upstream payload valid
o_rdy  out  1  stage can accept a beat
i_data  in  DATA_W  upstream payload
o_vld  out  1  downstream payload valid
i_rdy  in  1  downstream accepts
o_data  out  DATA_W  payload to downstream
o_occ  out  2  entries held (0..2; max 1 when SKID=0)
o_stall_cnt  out  CNT_W  saturating count of cycles with o_vld=1 and i_rdy=0
i_cnt_clr  in  1  synchronous clear of o_stall_cnt

Behaviour:
- Reset (async, i_rst_n=0):
  - All valids 0; o_occ=0; o_data=0; skid data=0; o_stall_cnt=0.
  - o_rdy=1 when SKID=1; o_rdy=1 when SKID=0, since o_vld=0.
- Handshakes: in_fire = i_vld & o_rdy; out_fire = o_vld & i_rdy.
- Ordering: strict FIFO order. No beat is duplicated or dropped except by flush.
- Hold rule: while o_vld=1 and i_rdy=0, o_data is held stable.
- Latency: 1 cycle. A beat accepted at edge N appears on o_vld/o_data after edge N when the stage was empty.
- SKID=1: states EMPTY (occ 0), ONE (main valid), FULL (main+skid valid). o_rdy = !skid_vld, from a register only.
  - EMPTY: in_fire -> main<=i_data, ONE. Otherwise stay.
  - ONE:
    - in_fire & out_fire -> main<=i_data, stay ONE.
    - in_fire & !out_fire -> skid<=i_data, FULL.
    - !in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - FULL: o_rdy=0, so no input accepted. out_fire -> main<=skid, skid_vld<=0, ONE.
  - Sustained i_vld=i_rdy=1 gives 1 beat/cycle throughput.
- SKID=0: o_rdy = !o_vld | i_rdy (combinational).
  - in_fire -> main<=i_data, o_vld<=1.
  - out_fire & !in_fire -> o_vld<=0.
  - Otherwise hold.
- Flush (i_flush=1 at edge):
  - Priority above all handshake activity.
  - Main and skid valids cleared; o_occ=0. Payloads cleared to 0 if CLR_ON_FLUSH=1, else unchanged.
  - Same-cycle input beat is discarded even though o_rdy may read 1.
  - Same-cycle out_fire still counts as delivered downstream; the stage simply empties.
  - After flush: SKID=1 -> o_rdy=1 next cycle.
- Stall counter:
  - Increments at each edge where o_vld=1 and i_rdy=0; saturates at 2^CNT_W-1.
  - i_cnt_clr has priority over increment: counter reads 0 next cycle.
  - Flush does not clear the counter.
- Reset asserted mid-operation: immediate clear per reset values. Entries held before reset are never emitted.
- i_vld without o_rdy is allowed; upstream must hold i_data/i_vld until in_fire. The stage does not check this.

Test Plan:
- Reset then streaming, SKID=1: i_vld=1, i_rdy=1, payloads 0x1,0x2,0x3 on consecutive cycles -> o_data 0x1,0x2,0x3 on the following 3 cycles; o_occ=1 throughout; o_rdy always 1; o_stall_cnt=0.
- Backpressure fill, SKID=1: send 0xA then 0xB with i_rdy=0 -> o_occ=2, o_rdy=0, o_data=0xA held. Raise i_rdy -> 0xA then 0xB delivered in order, o_rdy=1 one cycle after first out_fire. o_stall_cnt equals the number of cycles held.
- Flush while FULL with i_vld=1 carrying 0xC, CLR_ON_FLUSH=1 -> next cycle o_vld=0, o_occ=0, o_data=0. 0xC is never emitted. o_stall_cnt unchanged.
- SKID=0 mode: with o_vld=1 and i_rdy=0, drive i_vld with 0x5 -> o_rdy=0, 0x5 not accepted. Set i_rdy=1 -> o_rdy=1 same cycle, 0x5 replaces the old beat with no bubble.
- Counter saturation, CNT_W=4: hold o_vld=1, i_rdy=0 for 20 cycles -> o_stall_cnt=15. Pulse i_cnt_clr together with a stall cycle -> 0.
- Async reset asserted while FULL with 0x7/0x8 held -> outputs go to reset values immediately, without waiting for a clock edge. After release with i_rdy=1 and no new input, no beat appears.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Reusable valid/ready pipeline slice carrying an opaque payload, with flush,
// optional 2-entry skid buffer (registered o_rdy) and a saturating stall counter.
module pipe_stage_buf #(
    parameter int DATA_W       = 32,
    parameter int SKID         = 1,
    parameter int CLR_ON_FLUSH = 1,
    parameter int CNT_W        = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_vld,
    output logic              o_rdy,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_occ,
    output logic [CNT_W-1:0]  o_stall_cnt,
    input  logic              i_cnt_clr
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              rdy_q;
    logic              in_fire;
    logic              out_fire;

    assign o_vld    = (state != EMPTY);
    assign o_rdy    = (SKID != 0) ? rdy_q : (!o_vld || i_rdy);
    assign in_fire  = i_vld && o_rdy;
    assign out_fire = o_vld && i_rdy;
    assign o_data   = main_q;
    assign o_occ    = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
            rdy_q  <= 1'b1;
        end else if (i_flush) begin
            // Flush wins over any handshake; a same-cycle input beat is dropped.
            state <= EMPTY;
            rdy_q <= 1'b1;
            if (CLR_ON_FLUSH != 0) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= i_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= i_data;
                    end else if (in_fire) begin
                        // Only reachable in skid mode: park the beat behind main.
                        skid_q <= i_data;
                        state  <= FULL;
                        rdy_q  <= 1'b0;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= ONE;
                        rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= EMPTY;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_stall_cnt <= '0;
        end else if (o_vld && !i_rdy && (o_stall_cnt != CNT_MAX)) begin
            o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end

endmodule
